// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the floating-point multiplier
package fp_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef struct packed {
    logic                s;
    logic [FP_EXP_W-1:0] e;
    logic [FP_MAN_W-1:0] m;
  } fp_op_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical quiet NaN: positive, exponent all ones, only the top mantissa bit set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - normalise, round-to-nearest-even and special-value select
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                          i_sign,
  input  fp_class_t                     i_ca,
  input  fp_class_t                     i_cb,
  input  logic [2*(MAN_W+1)-1:0]        i_prod,
  input  logic signed [EXP_W+1:0]       i_exp,
  output logic [EXP_W+MAN_W:0]          o_res,
  output logic                          o_ovf,
  output logic                          o_unf,
  output logic                          o_inv
);

  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam int XW = EXP_W + 2;
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam logic [63:0]   QNAN64  = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]  QNAN    = QNAN64[W-1:0];
  localparam logic [XW-1:0] EXP_TOP = XW'(fp_exp_max(EXP_W));

  logic [PW-1:0]          w_norm;
  logic [MW-1:0]          w_man_full;
  logic                   w_guard, w_round, w_sticky, w_up;
  logic [MW:0]            w_rnd;
  logic signed [XW-1:0]   w_exp_f;
  logic                   w_is_ovf, w_is_unf;
  logic                   w_any_nan, w_any_inf, w_any_zero;

  // Product of two [1,2) significands lies in [1,4): at most one left shift normalises it.
  assign w_norm     = i_prod[PW-1] ? i_prod : (i_prod << 1);
  assign w_man_full = w_norm[PW-1 -: MW];
  assign w_guard    = w_norm[MW-1];
  assign w_round    = w_norm[MW-2];
  assign w_sticky   = |w_norm[MW-3:0];
  assign w_up       = w_guard & (w_round | w_sticky | w_man_full[0]);
  assign w_rnd      = {1'b0, w_man_full} + (MW+1)'(w_up);
  assign w_exp_f    = i_exp + $signed(XW'(i_prod[PW-1])) + $signed(XW'(w_rnd[MW]));

  assign w_is_unf   = w_exp_f[XW-1] | (w_exp_f == '0);
  assign w_is_ovf   = !w_exp_f[XW-1] && (w_exp_f >= EXP_TOP);

  assign w_any_nan  = (i_ca == NAN) || (i_cb == NAN);
  assign w_any_inf  = (i_ca == INF) || (i_cb == INF);
  assign w_any_zero = (i_ca == ZERO) || (i_cb == ZERO);

  // A rounding carry leaves w_rnd = 10..0, so its low MAN_W bits are already the renormalised fraction.
  always_comb begin
    o_res = {i_sign, w_exp_f[EXP_W-1:0], w_rnd[MAN_W-1:0]};
    o_ovf = 1'b0;
    o_unf = 1'b0;
    o_inv = 1'b0;
    if (w_any_nan || (w_any_inf && w_any_zero)) begin
      o_res = QNAN;
      o_inv = 1'b1;
    end else if (w_any_inf) begin
      o_res = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_any_zero) begin
      o_res = {i_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end else if (w_is_ovf) begin
      o_res = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_ovf = 1'b1;
    end else if (w_is_unf) begin
      o_res = {i_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      o_unf = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - pipelined floating-point multiplier with valid/ready handshake
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = fp_bias(EXP_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam int XW = EXP_W + 2;

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return ZERO;
    if (&e) return (m == '0) ? INF : NAN;
    return NORM;
  endfunction

  logic                 w_adv;
  logic                 r0_valid;
  logic [W-1:0]         r0_a, r0_b;
  logic                 r1_valid, r1_sign;
  fp_class_t            r1_ca, r1_cb;
  logic [MW-1:0]        r1_ma, r1_mb;
  logic signed [XW-1:0] r1_exp;
  logic                 r2_valid, r2_sign;
  fp_class_t            r2_ca, r2_cb;
  logic [PW-1:0]        r2_prod;
  logic signed [XW-1:0] r2_exp;
  logic [W-1:0]         w_res;
  logic                 w_ovf, w_unf, w_inv;
  logic [EXP_W-1:0]     w_ea, w_eb;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_ea     = r0_a[W-2 -: EXP_W];
  assign w_eb     = r0_b[W-2 -: EXP_W];

  // Operands are captured raw first so classification starts from a registered boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_valid  <= 1'b0;
      r1_valid  <= 1'b0;
      r2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_inv  <= 1'b0;
    end else if (w_adv) begin
      r0_valid  <= in_valid;
      r0_a      <= a;
      r0_b      <= b;
      r1_valid  <= r0_valid;
      r1_sign   <= r0_a[W-1] ^ r0_b[W-1];
      r1_ca     <= classify(w_ea, r0_a[MAN_W-1:0]);
      r1_cb     <= classify(w_eb, r0_b[MAN_W-1:0]);
      r1_ma     <= {1'b1, r0_a[MAN_W-1:0]};
      r1_mb     <= {1'b1, r0_b[MAN_W-1:0]};
      r1_exp    <= $signed(XW'(w_ea) + XW'(w_eb) - XW'(BIAS));
      r2_valid  <= r1_valid;
      r2_sign   <= r1_sign;
      r2_ca     <= r1_ca;
      r2_cb     <= r1_cb;
      r2_prod   <= PW'(r1_ma) * PW'(r1_mb);
      r2_exp    <= r1_exp;
      out_valid <= r2_valid;
      out       <= r2_valid ? w_res : '0;
      flag_ovf  <= r2_valid & w_ovf;
      flag_unf  <= r2_valid & w_unf;
      flag_inv  <= r2_valid & w_inv;
    end
  end

  fp_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm_round (
    .i_sign (r2_sign),
    .i_ca   (r2_ca),
    .i_cb   (r2_cb),
    .i_prod (r2_prod),
    .i_exp  (r2_exp),
    .o_res  (w_res),
    .o_ovf  (w_ovf),
    .o_unf  (w_unf),
    .o_inv  (w_inv)
  );

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed vector bench for fp_mul_pipe
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        sp_in_valid, sp_in_ready, sp_out_valid, sp_out_ready;
  logic [31:0] sp_a, sp_b, sp_out;
  logic        sp_ovf, sp_unf, sp_inv;
  logic        hp_in_valid, hp_in_ready, hp_out_valid, hp_out_ready;
  logic [15:0] hp_a, hp_b, hp_out;
  logic        hp_ovf, hp_unf, hp_inv;

  always #5 clk = ~clk;

  fp_mul_pipe u_sp (
    .clk(clk), .rst(rst), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
    .a(sp_a), .b(sp_b), .out_valid(sp_out_valid), .out_ready(sp_out_ready),
    .out(sp_out), .flag_ovf(sp_ovf), .flag_unf(sp_unf), .flag_inv(sp_inv)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .rst(rst), .in_valid(hp_in_valid), .in_ready(hp_in_ready),
    .a(hp_a), .b(hp_b), .out_valid(hp_out_valid), .out_ready(hp_out_ready),
    .out(hp_out), .flag_ovf(hp_ovf), .flag_unf(hp_unf), .flag_inv(hp_inv)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    chk({v.name, " in_ready"}, 64'(sp_in_ready), 64'd1);
    sp_in_valid  = 1'b1;
    sp_a         = v.a;
    sp_b         = v.b;
    sp_out_ready = 1'b1;
    tick();
    sp_in_valid = 1'b0;
    lat = 0;
    while (!sp_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({v.name, " latency"}, 64'(lat), 64'd3);
    chk({v.name, " result"}, 64'(sp_out), 64'(v.res));
    chk({v.name, " flags"}, 64'({sp_ovf, sp_unf, sp_inv}), 64'(v.flags));
    tick();
  endtask

  initial begin
    int          pat[4];
    int          tx, rx, cyc, lat;
    logic        acc, stalled;
    logic [34:0] held;

    vecs[0] = '{"mul_1p5x2",  32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000};
    vecs[1] = '{"rnd_sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
    vecs[2] = '{"rnd_tie",    32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000};
    vecs[3] = '{"ovf",        32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100};
    vecs[4] = '{"inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001};
    vecs[5] = '{"unf_pos",    32'h00800000, 32'h3F000000, 32'h00000000, 3'b010};
    vecs[6] = '{"nan_in",     32'h7FA00000, 32'h3F800000, 32'h7FC00000, 3'b001};
    vecs[7] = '{"unf_neg",    32'h80800000, 32'h3F000000, 32'h80000000, 3'b010};
    vecs[8] = '{"ninf_x2",    32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
    pat = '{1, 0, 0, 1};

    rst = 1'b1;
    sp_in_valid = 1'b0; sp_a = '0; sp_b = '0; sp_out_ready = 1'b1;
    hp_in_valid = 1'b0; hp_a = '0; hp_b = '0; hp_out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset out_valid", 64'(sp_out_valid), 64'd0);
    chk("reset out", 64'(sp_out), 64'd0);
    chk("reset flags", 64'({sp_ovf, sp_unf, sp_inv}), 64'd0);
    chk("reset in_ready", 64'(sp_in_ready), 64'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Streaming with a 1,0,0,1 backpressure pattern.
    tx = 0; rx = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (rx < 8 && cyc < 200) begin
      if (stalled)
        chk("stall hold", 64'({sp_out_valid, sp_out, sp_ovf, sp_unf, sp_inv}), 64'({1'b1, held}));
      sp_out_ready = pat[cyc % 4][0];
      sp_in_valid  = (tx < 8);
      sp_a         = vecs[tx % 9].a;
      sp_b         = vecs[tx % 9].b;
      #1;
      chk("stream in_ready", 64'(sp_in_ready), 64'(!sp_out_valid || sp_out_ready));
      acc = sp_in_valid && sp_in_ready;
      if (sp_out_valid && sp_out_ready) begin
        chk({"stream ", vecs[rx].name}, 64'({sp_out, sp_ovf, sp_unf, sp_inv}),
            64'({vecs[rx].res, vecs[rx].flags}));
        rx++;
      end
      stalled = sp_out_valid && !sp_out_ready;
      held    = {sp_out, sp_ovf, sp_unf, sp_inv};
      tick();
      cyc++;
      if (acc) tx++;
    end
    sp_in_valid  = 1'b0;
    sp_out_ready = 1'b1;
    chk("stream accepted", 64'(tx), 64'd8);
    chk("stream delivered", 64'(rx), 64'd8);
    for (int i = 0; i < 5; i++) begin
      chk("stream no extra", 64'(sp_out_valid), 64'd0);
      tick();
    end

    // Reset with three items in flight discards them all.
    for (int i = 0; i < 3; i++) begin
      sp_in_valid = 1'b1;
      sp_a = vecs[i].a;
      sp_b = vecs[i].b;
      tick();
    end
    sp_in_valid = 1'b0;
    chk("inflight not out yet", 64'(sp_out_valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("flush out_valid", 64'(sp_out_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("flush stays idle", 64'(sp_out_valid), 64'd0);
    end
    run_vec(vecs[0]);

    // Half precision: 1.5 * 2.0 = 3.0.
    hp_in_valid = 1'b1;
    hp_a = 16'h3E00;
    hp_b = 16'h4000;
    tick();
    hp_in_valid = 1'b0;
    lat = 0;
    while (!hp_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("hp latency", 64'(lat), 64'd3);
    chk("hp result", 64'(hp_out), 64'h4200);
    chk("hp flags", 64'({hp_ovf, hp_unf, hp_inv}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
